// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: board-level reset sequencer.
// Combines the power-on reset, PLL lock and a debounced reset button into staged
// active-low resets. Stage 0 (peripherals) is released first and stage NumStages-1
// (core) last. The cause of the most recent abort is recorded.
//
// Optional feature: define RST_SEQ_WDT_EN to build a watchdog that aborts the
// sequence (cause 2'b11) when RUN lasts WdtCycles-1 cycles without a wdt_kick_i pulse.
//
// Ports:
//   clk_sys_i     system clock
//   rst_sys_ni    asynchronous active-low reset
//   pll_locked_i  PLL lock (asynchronous, high = locked)
//   btn_rst_i     raw reset button (asynchronous, high = pressed)
//   wdt_kick_i    watchdog kick pulse (synchronous)
//   rst_stage_no  per-stage active-low resets (flop outputs)
//   seq_busy_o    high whenever the sequencer is not in RUN
//   rst_cause_o   last abort cause: 00 power-on, 01 button, 10 PLL loss, 11 watchdog
module rst_seq_ctrl #(
  parameter int unsigned DebounceCycles = 50000,
  parameter int unsigned StretchCycles  = 16,
  parameter int unsigned StageGap       = 8,
  parameter int unsigned NumStages      = 3,
  parameter int unsigned WdtCycles      = 1048576
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_ni,
  input  logic                 pll_locked_i,
  input  logic                 btn_rst_i,
  input  logic                 wdt_kick_i,
  output logic [NumStages-1:0] rst_stage_no,
  output logic                 seq_busy_o,
  output logic [1:0]           rst_cause_o
);

  localparam int unsigned DebW   = $clog2(DebounceCycles) + 1;
  localparam int unsigned SeqMax = (StretchCycles > StageGap) ? StretchCycles : StageGap;
  localparam int unsigned SeqW   = $clog2(SeqMax) + 1;

  typedef enum logic [1:0] {StHold, StStretch, StRelease, StRun} state_e;

  state_e                state_q, state_d;
  logic [1:0]            pll_sync_q, btn_sync_q;
  logic                  btn_deb_q, btn_deb_d;
  logic [DebW-1:0]       deb_cnt_q, deb_cnt_d;
  logic [SeqW-1:0]       seq_cnt_q, seq_cnt_d;
  logic [NumStages-1:0]  stage_q, stage_d;
  logic                  busy_q, busy_d;
  logic [1:0]            cause_q, cause_d;
  logic                  pll_ok, wdt_timeout, abort;

  assign pll_ok = pll_sync_q[1];

  // Debounce: count consecutive mismatches between the synchronized button and the
  // accepted level; any match restarts the count.
  always_comb begin
    btn_deb_d = btn_deb_q;
    deb_cnt_d = '0;
    if (btn_sync_q[1] != btn_deb_q) begin
      if (deb_cnt_q == DebW'(DebounceCycles - 1)) begin
        btn_deb_d = ~btn_deb_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

`ifdef RST_SEQ_WDT_EN
  localparam int unsigned WdtW = $clog2(WdtCycles) + 1;
  logic [WdtW-1:0] wdt_cnt_q, wdt_cnt_d;

  assign wdt_timeout = (wdt_cnt_q == WdtW'(WdtCycles - 1));

  always_comb begin
    wdt_cnt_d = '0;
    if ((state_q == StRun) && !wdt_kick_i && !wdt_timeout) begin
      wdt_cnt_d = wdt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      wdt_cnt_q <= '0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
    end
  end
`else
  logic unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick_i;
  assign wdt_timeout     = 1'b0;
`endif

  assign abort = !pll_ok || btn_deb_q || wdt_timeout;

  always_comb begin
    state_d   = state_q;
    seq_cnt_d = seq_cnt_q;
    stage_d   = stage_q;
    cause_d   = cause_q;
    unique case (state_q)
      StHold: begin
        stage_d   = '0;
        seq_cnt_d = '0;
        if (pll_ok && !btn_deb_q) begin
          state_d = StStretch;
        end
      end
      StStretch: begin
        if (seq_cnt_q == SeqW'(StretchCycles - 1)) begin
          // Entry into RELEASE frees stage 0 on the same edge.
          seq_cnt_d = '0;
          stage_d   = (stage_q << 1) | NumStages'(1);
          state_d   = (&stage_d) ? StRun : StRelease;
        end else begin
          seq_cnt_d = seq_cnt_q + 1'b1;
        end
      end
      StRelease: begin
        if (seq_cnt_q == SeqW'(StageGap - 1)) begin
          seq_cnt_d = '0;
          stage_d   = (stage_q << 1) | NumStages'(1);
          state_d   = (&stage_d) ? StRun : StRelease;
        end else begin
          seq_cnt_d = seq_cnt_q + 1'b1;
        end
      end
      StRun: state_d = StRun;
      default: state_d = StHold;
    endcase

    if ((state_q != StHold) && abort) begin
      state_d   = StHold;
      stage_d   = '0;
      seq_cnt_d = '0;
      cause_d   = !pll_ok ? 2'b10 : (wdt_timeout ? 2'b11 : 2'b01);
    end

    busy_d = (state_d != StRun);
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      pll_sync_q <= '0;
      btn_sync_q <= '0;
      btn_deb_q  <= 1'b0;
      deb_cnt_q  <= '0;
      state_q    <= StHold;
      seq_cnt_q  <= '0;
      stage_q    <= '0;
      busy_q     <= 1'b1;
      cause_q    <= 2'b00;
    end else begin
      pll_sync_q <= {pll_sync_q[0], pll_locked_i};
      btn_sync_q <= {btn_sync_q[0], btn_rst_i};
      btn_deb_q  <= btn_deb_d;
      deb_cnt_q  <= deb_cnt_d;
      state_q    <= state_d;
      seq_cnt_q  <= seq_cnt_d;
      stage_q    <= stage_d;
      busy_q     <= busy_d;
      cause_q    <= cause_d;
    end
  end

  assign rst_stage_no = stage_q;
  assign seq_busy_o   = busy_q;
  assign rst_cause_o  = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Testbench for rst_seq_ctrl: directed stimulus, an edge-timestamp reference model
// checked every cycle, and literal expectations at hand-computed edges.
module tb_rst_seq_ctrl;

  localparam int D = 4;
  localparam int S = 16;
  localparam int G = 8;
  localparam int N = 3;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pll = 1'b1;
  logic         btn = 1'b0;
  logic         kick = 1'b0;
  logic [N-1:0] stage;
  logic         busy;
  logic [1:0]   cause;

  int n_pass = 0;
  int n_total = 0;

  rst_seq_ctrl #(
    .DebounceCycles(D),
    .StretchCycles (S),
    .StageGap      (G),
    .NumStages     (N),
    .WdtCycles     (W)
  ) dut (
    .clk_sys_i   (clk),
    .rst_sys_ni  (rst_n),
    .pll_locked_i(pll),
    .btn_rst_i   (btn),
    .wdt_kick_i  (kick),
    .rst_stage_no(stage),
    .seq_busy_o  (busy),
    .rst_cause_o (cause)
  );

  always #5 clk = ~clk;

  // Reference model: state after edge edge_n (edges counted from reset release).
  int       edge_n = 0;
  bit       m_active = 1'b0;  // sequence started at edge m_e and not aborted since
  int       m_e = 0;
  int       m_kick = -100000;
  bit [1:0] m_cause = 2'b00;
  bit       m_deb = 1'b0;
  int       m_run = 0;
  bit [1:0] ph = 2'b00;
  bit [1:0] bh = 2'b00;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        edge_n = 0; m_active = 1'b0; m_e = 0; m_kick = -100000; m_cause = 2'b00;
        m_deb = 1'b0; m_run = 0; ph = 2'b00; bh = 2'b00;
      end else begin
        bit pll_s, btn_s, to;
        int r, rf;
        edge_n = edge_n + 1;
        pll_s = ph[1];
        btn_s = bh[1];
        to = 1'b0;
        r = m_e + S + (N - 1) * G;
        rf = (m_kick > r) ? m_kick : r;
`ifdef RST_SEQ_WDT_EN
        if (m_active && (edge_n - 1 >= r) && (edge_n - 1 - rf == W - 1)) to = 1'b1;
`else
        if (rf < 0) to = 1'b0;
`endif
        if (m_active) begin
          if (!pll_s || m_deb || to) begin
            m_active = 1'b0;
            m_cause = !pll_s ? 2'b10 : (to ? 2'b11 : 2'b01);
          end
        end else if (pll_s && !m_deb) begin
          m_active = 1'b1;
          m_e = edge_n;
        end
        if (btn_s != m_deb) begin
          m_run = m_run + 1;
          if (m_run == D) begin
            m_deb = ~m_deb;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
        ph = {ph[0], pll};
        bh = {bh[0], btn};
        if (kick) m_kick = edge_n;
      end
    end
  end

  function automatic logic [N-1:0] exp_stage();
    logic [N-1:0] v;
    v = '0;
    if (m_active) begin
      for (int k = 0; k < N; k++) begin
        if (edge_n - m_e >= S + k * G) v[k] = 1'b1;
      end
    end
    return v;
  endfunction

  function automatic logic exp_busy();
    return !m_active || (edge_n - m_e < S + (N - 1) * G);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_total = n_total + 1;
    if (got == exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check("model_stage", int'(stage), int'(exp_stage()));
    check("model_busy", int'(busy), int'(exp_busy()));
    check("model_cause", int'(cause), int'(m_cause));
  endtask

  task automatic wait_edge(input int n);
    while (edge_n < n) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) step();
    check("reset_stage", int'(stage), 0);
    check("reset_busy", int'(busy), 1);
    check("reset_cause", int'(cause), 0);
    rst_n = 1'b1;

    // Power-on sequencing: E = edge 3
    wait_edge(18); check("po_e18", int'(stage), 3'b000);
    wait_edge(19); check("po_e19", int'(stage), 3'b001);
    wait_edge(27); check("po_e27", int'(stage), 3'b011);
    wait_edge(34); check("po_busy34", int'(busy), 1);
    wait_edge(35); check("po_e35", int'(stage), 3'b111);
    check("po_busy35", int'(busy), 0);
    check("po_cause", int'(cause), 2'b00);

    // Short bounce is filtered
    wait_edge(40); btn = 1'b1;
    wait_edge(43); btn = 1'b0;
    wait_edge(55); check("bounce", int'(stage), 3'b111);

    // Held press from edge 60
    wait_edge(60); btn = 1'b1;
    wait_edge(66); check("btn_e66", int'(stage), 3'b111);
    wait_edge(67); check("btn_e67", int'(stage), 3'b000);
    check("btn_cause", int'(cause), 2'b01);
    wait_edge(80); btn = 1'b0;
    wait_edge(102); check("rel_e102", int'(stage), 3'b000);
    wait_edge(103); check("rel_e103", int'(stage), 3'b001);
    wait_edge(119); check("rel_e119", int'(stage), 3'b111);

    // PLL loss in RUN, then again mid-RELEASE
    wait_edge(125); pll = 1'b0;
    wait_edge(127); check("pll_e127", int'(stage), 3'b111);
    wait_edge(128); check("pll_e128", int'(stage), 3'b000);
    check("pll_cause1", int'(cause), 2'b10);
    wait_edge(130); pll = 1'b1;
    wait_edge(149); check("pll_e149", int'(stage), 3'b001);
    wait_edge(150); pll = 1'b0;
    wait_edge(152); check("pll_e152", int'(stage), 3'b001);
    wait_edge(153); check("pll_e153", int'(stage), 3'b000);
    check("pll_cause2", int'(cause), 2'b10);
    wait_edge(170); check("pll_hold", int'(stage), 3'b000);
    pll = 1'b1;
    wait_edge(189); check("pll_e189", int'(stage), 3'b001);
    wait_edge(205); check("pll_e205", int'(stage), 3'b111);

    // Button and PLL loss register on the same edge (217)
    wait_edge(210); btn = 1'b1;
    wait_edge(214); pll = 1'b0;
    wait_edge(216); check("sim_e216", int'(stage), 3'b111);
    wait_edge(217); check("sim_e217", int'(stage), 3'b000);
    check("sim_cause", int'(cause), 2'b10);
    wait_edge(220); btn = 1'b0; pll = 1'b1;
    wait_edge(259); check("sim_e259", int'(stage), 3'b111);

    // Watchdog: kicks at 270/320/370, then none
    wait_edge(269); kick = 1'b1;
    wait_edge(270); kick = 1'b0;
    wait_edge(319); kick = 1'b1;
    wait_edge(320); kick = 1'b0;
    wait_edge(369); kick = 1'b1;
    wait_edge(370); kick = 1'b0;
    wait_edge(433); check("wdt_e433", int'(stage), 3'b111);
    wait_edge(434);
`ifdef RST_SEQ_WDT_EN
    check("wdt_e434", int'(stage), 3'b000);
    check("wdt_cause", int'(cause), 2'b11);
`else
    check("wdt_e434", int'(stage), 3'b111);
    check("wdt_cause", int'(cause), 2'b10);
`endif
    wait_edge(439); check("wdt_busy439", int'(busy), 1 - int'(stage == 3'b111));

    // Async reset mid-STRETCH (E = 448)
    wait_edge(440); pll = 1'b0;
    wait_edge(445); pll = 1'b1;
    wait_edge(455); check("str_cause", int'(cause), 2'b10);
    check("str_busy", int'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_stage", int'(stage), 0);
    check("async_busy", int'(busy), 1);
    check("async_cause", int'(cause), 0);
    repeat (2) step();
    rst_n = 1'b1;
    wait_edge(34); check("po2_e34", int'(stage), 3'b011);
    wait_edge(35); check("po2_e35", int'(stage), 3'b111);
    check("po2_busy", int'(busy), 0);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
